// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - trace record layout, watch kinds and width helpers
// Optional macro TRACE_TIMESTAMP_EN appends a 32-bit cycle stamp as the record MSB field.
package trace_pkg;

  localparam logic [1:0] WK_PC  = 2'd0;
  localparam logic [1:0] WK_REG = 2'd1;
  localparam logic [1:0] WK_MEM = 2'd2;

  localparam int FLAG_RF  = 0;
  localparam int FLAG_MEM = 1;
  localparam int FLAGS_W  = 2;

`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W = 32;
`else
  localparam int TS_W = 0;
`endif

  // Record, LSB first: data, addr, pc, hit_any, flags[1:0] {mem_we, rf_we}, [timestamp]
  function automatic int off_addr(input int dw);
    return dw;
  endfunction

  function automatic int off_pc(input int aw, input int dw);
    return dw + aw;
  endfunction

  function automatic int off_hit(input int aw, input int dw);
    return dw + 2 * aw;
  endfunction

  function automatic int off_flags(input int aw, input int dw);
    return dw + 2 * aw + 1;
  endfunction

  function automatic int off_ts(input int aw, input int dw);
    return dw + 2 * aw + 1 + FLAGS_W;
  endfunction

  function automatic int rec_w(input int aw, input int dw);
    return off_ts(aw, dw) + TS_W;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO with extra-MSB wrap pointers
// Output reads as zero while empty; a write into an empty FIFO shows up on the next cycle.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_rd, do_wr;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_rd   = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_wr   = push_i && (!full_o || do_rd);
  assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_wr) wr_d = wr_q + PTR_ONE;
    if (do_rd) rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/trace_monitor.sv
// rtl/trace_monitor.sv - commit trace capture, watchpoints and halt request for the MIPS retire point
// Optional macro TRACE_TIMESTAMP_EN stamps each record with a free-running cycle count.
module trace_monitor
  import trace_pkg::*;
#(
  parameter  int NUM_WATCH = 4,
  parameter  int DEPTH     = 16,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int OVF_W     = 16,
  localparam int IDX_W     = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1,
  localparam int REC_W     = rec_w(ADDR_W, DATA_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 commit_valid,
  input  logic [ADDR_W-1:0]    commit_pc,
  input  logic                 rf_we,
  input  logic [4:0]           rf_waddr,
  input  logic [DATA_W-1:0]    rf_wdata,
  input  logic                 mem_we,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mode_all,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic                 cfg_en,
  input  logic                 cfg_stop,
  input  logic [1:0]           cfg_kind,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [ADDR_W-1:0]    cfg_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REC_W-1:0]     out_rec,
  output logic                 halt_req,
  input  logic                 halt_clr,
  output logic [NUM_WATCH-1:0] hit_vec,
  output logic [OVF_W-1:0]     ovf_cnt,
  output logic                 proto_err
);

  localparam int O_ADDR  = off_addr(DATA_W);
  localparam int O_PC    = off_pc(ADDR_W, DATA_W);
  localparam int O_HIT   = off_hit(ADDR_W, DATA_W);
  localparam int O_FLAGS = off_flags(ADDR_W, DATA_W);

  logic [NUM_WATCH-1:0] en_q, stop_q;
  logic [1:0]           kind_q [NUM_WATCH];
  logic [ADDR_W-1:0]    addr_q [NUM_WATCH];
  logic [ADDR_W-1:0]    mask_q [NUM_WATCH];

  logic [NUM_WATCH-1:0] hit, hit_vec_q, hit_vec_d;
  logic                 halt_q, halt_d, proto_q, proto_d;
  logic [OVF_W-1:0]     ovf_q, ovf_d;
  logic [REC_W-1:0]     rec;
  logic                 hit_any, push, pop, full, empty;

  // Config registers update at the edge, so a concurrent commit still sees the old setup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q   <= '0;
      stop_q <= '0;
      for (int i = 0; i < NUM_WATCH; i++) begin
        kind_q[i] <= WK_PC;
        addr_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_WATCH; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          en_q[i]   <= cfg_en;
          stop_q[i] <= cfg_stop;
          kind_q[i] <= cfg_kind;
          addr_q[i] <= cfg_addr;
          mask_q[i] <= cfg_mask;
        end
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_WATCH; i++) begin
      case (kind_q[i])
        WK_PC:   hit[i] = (((commit_pc ^ addr_q[i]) & mask_q[i]) == '0);
        WK_REG:  hit[i] = rf_we && (((rf_waddr ^ addr_q[i][4:0]) & mask_q[i][4:0]) == 5'd0);
        WK_MEM:  hit[i] = mem_we && (((mem_addr ^ addr_q[i]) & mask_q[i]) == '0);
        default: hit[i] = 1'b0;
      endcase
      hit[i] = hit[i] && en_q[i] && commit_valid;
    end
  end

  assign hit_any = |hit;
  assign push    = commit_valid && (mode_all || hit_any);
  assign pop     = out_valid && out_ready;

`ifdef TRACE_TIMESTAMP_EN
  localparam int O_TS = off_ts(ADDR_W, DATA_W);
  logic [31:0] ts_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_q + 32'd1;
  end
`endif

  // Store fields take precedence when both write ports fire.
  always_comb begin
    rec = '0;
    rec[O_FLAGS + FLAG_RF]  = rf_we;
    rec[O_FLAGS + FLAG_MEM] = mem_we;
    rec[O_HIT]              = hit_any;
    rec[O_PC +: ADDR_W]     = commit_pc;
    if (mem_we) begin
      rec[O_ADDR +: ADDR_W] = mem_addr;
      rec[0 +: DATA_W]      = mem_wdata;
    end else if (rf_we) begin
      rec[O_ADDR +: ADDR_W] = ADDR_W'(rf_waddr);
      rec[0 +: DATA_W]      = rf_wdata;
    end
`ifdef TRACE_TIMESTAMP_EN
    rec[O_TS +: 32] = ts_q;
`endif
  end

  always_comb begin
    hit_vec_d = commit_valid ? hit : hit_vec_q;
    halt_d    = (halt_q && !halt_clr) || |(hit & stop_q);
    proto_d   = proto_q || (commit_valid && rf_we && mem_we);
    ovf_d     = ovf_q;
    if (push && full && !pop && (ovf_q != '1)) ovf_d = ovf_q + OVF_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_vec_q <= '0;
      halt_q    <= 1'b0;
      proto_q   <= 1'b0;
      ovf_q     <= '0;
    end else begin
      hit_vec_q <= hit_vec_d;
      halt_q    <= halt_d;
      proto_q   <= proto_d;
      ovf_q     <= ovf_d;
    end
  end

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (rec),
    .data_o  (out_rec),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_valid = !empty;
  assign hit_vec   = hit_vec_q;
  assign halt_req  = halt_q;
  assign proto_err = proto_q;
  assign ovf_cnt   = ovf_q;

endmodule

// File: doc/trace_monitor.md
Name: trace_monitor

Overview:
- Synthesizable commit-trace and watchpoint unit attached to the single-cycle MIPS core's retire point (PC, instruction, register-file write port, data-memory write port).
- Captures architectural events into a parametrised FIFO drained by a valid/ready port.
- Compares events against NUM_WATCH programmable watchpoints and raises a sticky halt request on a matching stop-enabled watch.
- Replaces ad-hoc simulation monitors with on-chip, filterable, buffered tracing.

Parameters:
- NUM_WATCH, 4: number of watchpoint channels, 1..16.
- DEPTH, 16: trace FIFO entries; power of 2, >= 2.
- ADDR_W, 32: PC / data-address width.
- DATA_W, 32: register / memory data width.
- OVF_W, 16: overflow counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- commit_valid  in  1  one instruction retires this cycle.
- commit_pc  in  ADDR_W  PC of the retiring instruction.
- rf_we  in  1  register write this commit.
- rf_waddr  in  5  destination register.
- rf_wdata  in  DATA_W  register write data.
- mem_we  in  1  data-memory store this commit.
- mem_addr  in  ADDR_W  store byte address.
- mem_wdata  in  DATA_W  store data.
- mode_all  in  1  1 = trace every commit; 0 = trace only watch hits.
- cfg_we  in  1  watchpoint write strobe.
- cfg_idx  in  $clog2(NUM_WATCH) (min 1)  channel selected.
- cfg_en, cfg_stop  in  1 each  channel enable; halt-on-hit.
- cfg_kind  in  2  0=PC, 1=REG, 2=MEM, 3=reserved (never matches).
- cfg_addr, cfg_mask  in  ADDR_W each  compare value; care mask (1 = compare this bit).
- out_valid  out  1  trace record available.
- out_ready  in  1  consumer accepts the record.
- out_rec  out  REC_W  head record (layout defined in trace_pkg).
- halt_req  out  1  sticky stop request to the core.
- halt_clr  in  1  clears halt_req.
- hit_vec  out  NUM_WATCH  registered per-channel hit flags of the last commit.
- ovf_cnt  out  OVF_W  count of dropped records, saturating.
- proto_err  out  1  sticky: rf_we and mem_we asserted together.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, out_valid=0, out_rec=0, halt_req=0, hit_vec=0, ovf_cnt=0, proto_err=0, all watch channels disabled.
- Match per channel, valid only when commit_valid:
  - PC: (commit_pc & mask) == (addr & mask).
  - REG: rf_we and (rf_waddr & mask[4:0]) == (addr[4:0] & mask[4:0]).
  - MEM: mem_we and (mem_addr & mask) == (addr & mask).
  - A disabled channel never hits.
- hit_vec updates on every commit_valid cycle and holds otherwise.
- Record fields: {flags[1:0] = {mem_we, rf_we}, hit_any, pc, addr, data}.
  - addr/data come from the mem port if mem_we, else from the rf port (rf_waddr zero-extended); zero if neither is asserted.
  - If rf_we and mem_we are both set, the mem fields win and proto_err is set.
- Push condition: commit_valid and (mode_all or any hit).
- Latency: the record is visible at out_rec / out_valid on the first clock edge after the commit.
- Handshake: pop when out_valid and out_ready. out_rec is stable while out_valid=1 and out_ready=0.
- Full, push without pop: record dropped; ovf_cnt++ saturating at all-ones.
- Full, push with pop in the same cycle: both occur; no drop.
- Empty: out_valid=0; a push in that cycle shows up the next cycle (no fall-through).
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally; full = MSBs differ and LSBs equal.
- halt_req: set the cycle after a hit on any stop-enabled channel. halt_clr clears it. Set has priority over simultaneous clear.
- A cfg write in the same cycle as a commit: that commit is compared against the old configuration; the new one applies from the next cycle.

Optional Feature:
- TRACE_TIMESTAMP_EN defined: a free-running 32-bit cycle counter (reset 0, wraps) is appended as the MSB field of every record; REC_W grows by 32.
- Undefined: no counter is built; the record has no timestamp field.

Decomposition:
- trace_pkg holds: watch-kind constants (WK_PC, WK_REG, WK_MEM), record field offsets/widths, the REC_W derivation (including the timestamp variant), and the flag bit positions.
- One sub-module: trace_fifo (parametrised DEPTH/WIDTH, push/pop/full/empty, extra-MSB pointers).

Test Plan:
- Reset mid-trace: 3 records queued, rst low for 1 ns -> out_valid=0, ovf_cnt=0, halt_req=0 immediately; a later commit is not traced when mode_all=0 and no watch is enabled.
- mode_all=1, commits at PC 0x0,0x4,0x8 with rf_we to reg 9 data 5,6,7 and out_ready=1 -> three records in order, each one cycle after its commit, flags=01, addr=9.
- mode_all=0, watch0 = MEM, addr 0x1008, mask 0xFFFFFFFF, stop=1; stores to 0x1000, 0x1008 -> exactly one record (addr 0x1008), hit_vec=0001, halt_req=1 the next cycle and held until halt_clr.
- out_ready=0, DEPTH+3 commits with mode_all=1 -> DEPTH records held, ovf_cnt=3; then pop and push in the same cycle while full -> no increment.
- Masked PC watch: addr 0x0040, mask 0xFFF0 -> hits at PC 0x40 and 0x4C, no hit at 0x50.
- rf_we=1 and mem_we=1 together -> record flags=11 carrying mem addr/data; proto_err=1 and sticky.
